tl_inflight_monitor: RTL and testbench

- Parametrised, synthesizable TileLink-UL/UH protocol monitor for one A/D channel pair.
- Sits passively beside a client/manager link in eval testbenches and in FPGA debug builds.
- Tracks per-source outstanding requests and multibeat burst progress on both channels.
- Flags protocol violations through an error pulse, an encoded cause and a sticky flag, replacing purely combinational per-field checks with stateful transaction checking.

---
 rtl/tl_mon_pkg.sv | 49 ++++
 rtl/tl_mon_beat_counter.sv | 68 ++++++
 rtl/tl_inflight_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_tl_inflight_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_mon_pkg.sv
// ---------------------------------------------------------------------------
// tl_mon_pkg
//
// Shared definitions for the TileLink in-flight monitor:
//   - A/D opcode constants the checks depend on
//   - err_code_e, the encoded violation cause (0 means no violation)
//   - table_entry_t, one per-source outstanding-request record
//   - beats(), the number of bus beats a message of a given size occupies
// ---------------------------------------------------------------------------
package tl_mon_pkg;

    // A opcodes 0..3 (PutFull, PutPartial, Arithmetic, Logical) carry data.
    // Get is 4. Anything above Get is rejected by this monitor.
    localparam logic [2:0] A_LOGICAL         = 3'd3;
    localparam logic [2:0] A_GET             = 3'd4;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    // Stored size field width; wide enough for any SIZE_BITS used here.
    localparam int ENTRY_SIZE_W = 8;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_A_OPCODE   = 4'd1,
        ERR_A_FIELD    = 4'd2,
        ERR_A_ALIGN    = 4'd3,
        ERR_DUP_SOURCE = 4'd4,
        ERR_D_UNKNOWN  = 4'd5,
        ERR_D_OPCODE   = 4'd6,
        ERR_D_SIZE     = 4'd7,
        ERR_D_SOURCE   = 4'd8
    } err_code_e;

    typedef struct packed {
        logic                    busy;
        logic                    is_get;
        logic [ENTRY_SIZE_W-1:0] size;
    } table_entry_t;

    // Messages no larger than one beat still take a single beat.
    function automatic int beats(input int size, input int beat_log2);
        if (size > beat_log2) begin
            return 1 << (size - beat_log2);
        end
        return 1;
    endfunction

endpackage

// File: rtl/tl_mon_beat_counter.sv
// ---------------------------------------------------------------------------
// tl_mon_beat_counter
//
// Tracks progress through a (possibly multibeat) message on one channel.
// The burst length is taken from size/multibeat on the first beat and held
// for the rest of the burst, so later-beat field changes cannot shorten or
// stretch the count.
//
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   fire            a beat is transferred this cycle
//   size            log2(bytes) of the message (sampled on the first beat)
//   multibeat       message carries data and may span several beats
//   first           the next beat to fire is the first of a message
//   last            the next beat to fire completes the message
// ---------------------------------------------------------------------------
module tl_mon_beat_counter
    import tl_mon_pkg::*;
#(
    parameter int SIZE_BITS = 3,
    parameter int BEAT_LOG2 = 3,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 fire,
    input  logic [SIZE_BITS-1:0] size,
    input  logic                 multibeat,
    output logic                 first,
    output logic                 last
);

    localparam logic [CNT_BITS:0] ONE = (CNT_BITS+1)'(1);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS:0]   total_q;
    logic [CNT_BITS:0]   total_now;
    logic [CNT_BITS:0]   total;

    always_comb begin
        total_now = ONE;
        if (multibeat) begin
            total_now = (CNT_BITS+1)'(beats(int'(size), BEAT_LOG2));
        end
        first = (count_q == '0);
        total = first ? total_now : total_q;
        last  = ({1'b0, count_q} == (total - ONE));
    end

    // Beat index wraps to 0 after the last beat so the next fire starts a
    // fresh message.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            total_q <= '0;
        end else if (fire) begin
            if (last) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CNT_BITS'(1);
            end
            if (first) begin
                total_q <= total_now;
            end
        end
    end

endmodule

// File: rtl/tl_inflight_monitor.sv
// ---------------------------------------------------------------------------
// tl_inflight_monitor
//
// Passive TileLink-UL/UH monitor for one A/D channel pair. Keeps a table of
// outstanding requests per source, follows multibeat bursts on both
// channels and reports protocol violations.
//
// Ports:
//   clock, reset_n                  clock and asynchronous active-low reset
//   a_valid, a_ready                A-channel handshake
//   a_opcode/size/source/address    A-channel request fields
//   d_valid, d_ready                D-channel handshake
//   d_opcode/size/source            D-channel response fields
//   err_valid                       one-cycle pulse, cycle after a violation
//   err_code                        cause of the most recent violation
//   err_sticky                      set by any violation until reset
//   inflight                        number of sources with a request pending
// ---------------------------------------------------------------------------
module tl_inflight_monitor
    import tl_mon_pkg::*;
#(
    parameter int SOURCE_BITS = 2,
    parameter int ADDR_BITS   = 25,
    parameter int SIZE_BITS   = 3,
    parameter int BEAT_LOG2   = 3,
    parameter int CNT_BITS    = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [ADDR_BITS-1:0]   a_address,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    output logic                   err_valid,
    output logic [3:0]             err_code,
    output logic                   err_sticky,
    output logic [SOURCE_BITS:0]   inflight
);

    localparam int NUM_SOURCES = 1 << SOURCE_BITS;

    logic a_fire, d_fire;
    logic a_first, a_last, d_first, d_last;

    // Fields latched from the first beat of the current A burst, and the
    // source of the current D burst.
    logic [2:0]             a_op_q;
    logic [SIZE_BITS-1:0]   a_size_q;
    logic [SOURCE_BITS-1:0] a_src_q;
    logic [ADDR_BITS-1:0]   a_addr_q;
    logic [SOURCE_BITS-1:0] d_src_q;

    table_entry_t table_q [NUM_SOURCES];
    table_entry_t table_d [NUM_SOURCES];

    logic                 err_valid_q;
    err_code_e            err_code_q;
    logic                 err_sticky_q;
    logic [SOURCE_BITS:0] inflight_q;

    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    tl_mon_beat_counter #(
        .SIZE_BITS (SIZE_BITS),
        .BEAT_LOG2 (BEAT_LOG2),
        .CNT_BITS  (CNT_BITS)
    ) u_a_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .fire      (a_fire),
        .size      (a_size),
        .multibeat (a_opcode <= A_LOGICAL),
        .first     (a_first),
        .last      (a_last)
    );

    tl_mon_beat_counter #(
        .SIZE_BITS (SIZE_BITS),
        .BEAT_LOG2 (BEAT_LOG2),
        .CNT_BITS  (CNT_BITS)
    ) u_d_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .fire      (d_fire),
        .size      (d_size),
        .multibeat (d_opcode == D_ACCESS_ACK_DATA),
        .first     (d_first),
        .last      (d_last)
    );

    // Violation detection and next table state. Later beats of a burst are
    // judged against the fields captured on its first beat, so a corrupted
    // beat is reported once rather than cascading into table errors.
    logic [2:0]             a_op_eff;
    logic [SIZE_BITS-1:0]   a_size_eff;
    logic [SOURCE_BITS-1:0] a_src_eff;
    logic [SOURCE_BITS-1:0] d_src_eff;
    logic [ADDR_BITS-1:0]   addr_mask;
    table_entry_t           d_entry;
    logic [2:0]             d_expect_op;
    logic                   d_retire;
    logic                   a_alloc_try;
    logic                   a_dup;
    logic                   e_a_opcode, e_a_field, e_a_align, e_dup;
    logic                   e_d_unknown, e_d_opcode, e_d_size, e_d_source;
    err_code_e              err_next;
    logic [SOURCE_BITS:0]   inflight_d;

    always_comb begin
        a_op_eff    = a_first ? a_opcode : a_op_q;
        a_size_eff  = a_first ? a_size   : a_size_q;
        a_src_eff   = a_first ? a_source : a_src_q;
        d_src_eff   = d_first ? d_source : d_src_q;
        addr_mask   = ADDR_BITS'((64'd1 << a_size) - 64'd1);
        d_entry     = table_q[d_src_eff];
        d_expect_op = d_entry.is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;

        d_retire    = d_fire & d_last;
        a_alloc_try = a_fire & a_last & (a_op_eff <= A_GET);
        // A response retiring the same source this cycle frees the slot.
        a_dup       = table_q[a_src_eff].busy &
                      ~(d_retire && (d_src_eff == a_src_eff));

        e_a_opcode  = a_fire & a_first & (a_opcode > A_GET);
        e_a_field   = a_fire & ~a_first &
                      ((a_opcode != a_op_q) || (a_size != a_size_q) ||
                       (a_source != a_src_q) || (a_address != a_addr_q));
        e_a_align   = a_fire & a_first & (|(a_address & addr_mask));
        e_dup       = a_alloc_try & a_dup;
        e_d_unknown = d_fire & ~d_entry.busy;
        e_d_opcode  = d_fire & d_entry.busy & (d_opcode != d_expect_op);
        e_d_size    = d_fire & d_entry.busy &
                      (d_entry.size != ENTRY_SIZE_W'(d_size));
        e_d_source  = d_fire & ~d_first & (d_source != d_src_q);

        err_next = ERR_NONE;
        if      (e_a_opcode)  err_next = ERR_A_OPCODE;
        else if (e_a_field)   err_next = ERR_A_FIELD;
        else if (e_a_align)   err_next = ERR_A_ALIGN;
        else if (e_dup)       err_next = ERR_DUP_SOURCE;
        else if (e_d_unknown) err_next = ERR_D_UNKNOWN;
        else if (e_d_opcode)  err_next = ERR_D_OPCODE;
        else if (e_d_size)    err_next = ERR_D_SIZE;
        else if (e_d_source)  err_next = ERR_D_SOURCE;

        // Retire first, then allocate, so a same-cycle reuse of one source
        // ends with the new request recorded.
        table_d = table_q;
        if (d_retire) begin
            table_d[d_src_eff] = '0;
        end
        if (a_alloc_try && !a_dup) begin
            table_d[a_src_eff].busy   = 1'b1;
            table_d[a_src_eff].is_get = (a_op_eff == A_GET);
            table_d[a_src_eff].size   = ENTRY_SIZE_W'(a_size_eff);
        end

        inflight_d = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            inflight_d = inflight_d + (SOURCE_BITS+1)'(table_d[i].busy);
        end
    end

    // State and registered outputs. err_code holds its last cause while
    // err_valid pulses only in the cycle after the violating fire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_op_q       <= '0;
            a_size_q     <= '0;
            a_src_q      <= '0;
            a_addr_q     <= '0;
            d_src_q      <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                table_q[i] <= '0;
            end
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_sticky_q <= 1'b0;
            inflight_q   <= '0;
        end else begin
            if (a_fire && a_first) begin
                a_op_q   <= a_opcode;
                a_size_q <= a_size;
                a_src_q  <= a_source;
                a_addr_q <= a_address;
            end
            if (d_fire && d_first) begin
                d_src_q <= d_source;
            end
            table_q     <= table_d;
            inflight_q  <= inflight_d;
            err_valid_q <= (err_next != ERR_NONE);
            if (err_next != ERR_NONE) begin
                err_code_q   <= err_next;
                err_sticky_q <= 1'b1;
            end
        end
    end

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// ---------------------------------------------------------------------------
// tb_tl_inflight_monitor
//
// Directed bench for tl_inflight_monitor. A transaction-level model tracks
// outstanding sources and remaining burst beats and predicts every output;
// a compare process checks the DUT against it on each falling edge, and the
// directed sequence adds hand-computed expectations at key points.
// ---------------------------------------------------------------------------
module tb_tl_inflight_monitor;

    localparam int SOURCE_BITS = 2;
    localparam int ADDR_BITS   = 25;
    localparam int SIZE_BITS   = 3;
    localparam int BEAT_LOG2   = 3;
    localparam int CNT_BITS    = 8;
    localparam int NUM_SOURCES = 1 << SOURCE_BITS;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   a_valid, a_ready;
    logic [2:0]             a_opcode;
    logic [SIZE_BITS-1:0]   a_size;
    logic [SOURCE_BITS-1:0] a_source;
    logic [ADDR_BITS-1:0]   a_address;
    logic                   d_valid, d_ready;
    logic [2:0]             d_opcode;
    logic [SIZE_BITS-1:0]   d_size;
    logic [SOURCE_BITS-1:0] d_source;
    logic                   err_valid;
    logic [3:0]             err_code;
    logic                   err_sticky;
    logic [SOURCE_BITS:0]   inflight;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    tl_inflight_monitor #(
        .SOURCE_BITS (SOURCE_BITS),
        .ADDR_BITS   (ADDR_BITS),
        .SIZE_BITS   (SIZE_BITS),
        .BEAT_LOG2   (BEAT_LOG2),
        .CNT_BITS    (CNT_BITS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_opcode   (a_opcode),
        .a_size     (a_size),
        .a_source   (a_source),
        .a_address  (a_address),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_opcode   (d_opcode),
        .d_size     (d_size),
        .d_source   (d_source),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .inflight   (inflight)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level model: outstanding table plus remaining-beat counts.
    int m_busy [NUM_SOURCES];
    int m_get  [NUM_SOURCES];
    int m_size [NUM_SOURCES];
    int m_a_left, m_a_op, m_a_size, m_a_src, m_a_addr;
    int m_d_left, m_d_src;
    int m_err_valid, m_err_code, m_err_sticky, m_inflight;

    function automatic int model_beats(input int size);
        return (size > BEAT_LOG2) ? (1 << (size - BEAT_LOG2)) : 1;
    endfunction

    function automatic int lowest(input int cur, input int c);
        return (cur == 0 || c < cur) ? c : cur;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int code, a_end, a_ok, d_end, d_src, alloc, total;
        if (!reset_n) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                m_busy[i] = 0;
                m_get[i]  = 0;
                m_size[i] = 0;
            end
            m_a_left = 0; m_a_op = 0; m_a_size = 0; m_a_src = 0; m_a_addr = 0;
            m_d_left = 0; m_d_src = 0;
            m_err_valid = 0; m_err_code = 0; m_err_sticky = 0; m_inflight = 0;
        end else begin
            code = 0; a_end = 0; a_ok = 0; d_end = 0; d_src = 0; alloc = 0;
            if (a_valid && a_ready) begin
                if (m_a_left == 0) begin
                    m_a_op = a_opcode; m_a_size = a_size;
                    m_a_src = a_source; m_a_addr = a_address;
                    if (a_opcode > 4) code = lowest(code, 1);
                    if ((int'(a_address) % (1 << a_size)) != 0) code = lowest(code, 3);
                    total = (a_opcode <= 3) ? model_beats(a_size) : 1;
                    m_a_left = total - 1;
                end else begin
                    if (a_opcode != m_a_op || a_size != m_a_size ||
                        a_source != m_a_src || a_address != m_a_addr)
                        code = lowest(code, 2);
                    m_a_left--;
                end
                a_end = (m_a_left == 0);
                a_ok  = (m_a_op <= 4);
            end
            if (d_valid && d_ready) begin
                if (m_d_left == 0) begin
                    m_d_src = d_source;
                    total = (d_opcode == 1) ? model_beats(d_size) : 1;
                    m_d_left = total - 1;
                end else begin
                    if (d_source != m_d_src) code = lowest(code, 8);
                    m_d_left--;
                end
                d_src = m_d_src;
                if (m_busy[d_src] == 0) begin
                    code = lowest(code, 5);
                end else begin
                    if (d_opcode != ((m_get[d_src] != 0) ? 1 : 0)) code = lowest(code, 6);
                    if (d_size != m_size[d_src]) code = lowest(code, 7);
                end
                d_end = (m_d_left == 0);
            end
            if (a_end && a_ok) begin
                if (m_busy[m_a_src] != 0 && !(d_end && d_src == m_a_src))
                    code = lowest(code, 4);
                else
                    alloc = 1;
            end
            if (d_end) m_busy[d_src] = 0;
            if (alloc) begin
                m_busy[m_a_src] = 1;
                m_get[m_a_src]  = (m_a_op == 4) ? 1 : 0;
                m_size[m_a_src] = m_a_size;
            end
            m_err_valid = (code != 0) ? 1 : 0;
            if (code != 0) begin
                m_err_code = code;
                m_err_sticky = 1;
            end
            m_inflight = 0;
            for (int i = 0; i < NUM_SOURCES; i++) m_inflight += m_busy[i];
        end
    end

    // Compare DUT against the model every cycle out of reset.
    always @(negedge clock) begin
        if (reset_n) begin
            check_output("model err_valid", int'(err_valid), m_err_valid);
            check_output("model err_code", int'(err_code), m_err_code);
            check_output("model err_sticky", int'(err_sticky), m_err_sticky);
            check_output("model inflight", int'(inflight), m_inflight);
        end
    end

    task automatic drive_idle();
        a_valid = 1'b0; a_ready = 1'b0; a_opcode = '0; a_size = '0;
        a_source = '0; a_address = '0;
        d_valid = 1'b0; d_ready = 1'b0; d_opcode = '0; d_size = '0; d_source = '0;
    endtask

    // Drives one cycle of A/D signals, returning 1 time unit after the edge
    // that samples them with the inputs idled again.
    task automatic apply_stimulus(input logic av, input logic ar, input int aop,
                                  input int asz, input int asrc, input int aaddr,
                                  input logic dv, input logic dr, input int dop,
                                  input int dsz, input int dsrc);
        a_valid = av; a_ready = ar; a_opcode = 3'(aop); a_size = SIZE_BITS'(asz);
        a_source = SOURCE_BITS'(asrc); a_address = ADDR_BITS'(aaddr);
        d_valid = dv; d_ready = dr; d_opcode = 3'(dop); d_size = SIZE_BITS'(dsz);
        d_source = SOURCE_BITS'(dsrc);
        @(posedge clock);
        #1;
        drive_idle();
    endtask

    task automatic send_a(input int op, input int sz, input int src, input int addr);
        apply_stimulus(1'b1, 1'b1, op, sz, src, addr, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic send_d(input int op, input int sz, input int src);
        apply_stimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, op, sz, src);
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset err_valid", int'(err_valid), 0);
        check_output("reset err_code", int'(err_code), 0);
        check_output("reset err_sticky", int'(err_sticky), 0);
        check_output("reset inflight", int'(inflight), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Get then AccessAckData on source 1
        send_a(4, 3, 1, 'h10);
        check_output("get inflight", int'(inflight), 1);
        check_output("get err_valid", int'(err_valid), 0);
        send_d(1, 3, 1);
        check_output("ackdata inflight", int'(inflight), 0);
        check_output("ackdata sticky", int'(err_sticky), 0);

        // 4-beat AccessAckData retires only on its last beat
        send_a(4, 5, 0, 'h40);
        for (int i = 0; i < 3; i++) send_d(1, 5, 0);
        check_output("d burst mid inflight", int'(inflight), 1);
        send_d(1, 5, 0);
        check_output("d burst end inflight", int'(inflight), 0);
        check_output("d burst sticky", int'(err_sticky), 0);

        // 4-beat PutFull with address changed on beat 2
        send_a(0, 5, 0, 'h20);
        send_a(0, 5, 0, 'h28);
        check_output("put field err_valid", int'(err_valid), 1);
        check_output("put field err_code", int'(err_code), 2);
        check_output("put field sticky", int'(err_sticky), 1);
        send_a(0, 5, 0, 'h20);
        check_output("put pulse ends", int'(err_valid), 0);
        check_output("put code held", int'(err_code), 2);
        send_a(0, 5, 0, 'h20);
        check_output("put alloc inflight", int'(inflight), 1);
        send_d(0, 5, 0);
        check_output("put retire inflight", int'(inflight), 0);

        // Duplicate source
        send_a(4, 3, 2, 0);
        send_a(4, 3, 2, 0);
        check_output("dup err_code", int'(err_code), 4);
        check_output("dup err_valid", int'(err_valid), 1);
        check_output("dup inflight", int'(inflight), 1);
        send_d(1, 3, 2);
        check_output("dup retire inflight", int'(inflight), 0);

        // Response with nothing outstanding, then wrong D opcode
        send_d(0, 3, 3);
        check_output("unknown src err_code", int'(err_code), 5);
        send_a(4, 2, 3, 4);
        check_output("get3 err_valid", int'(err_valid), 0);
        send_d(0, 2, 3);
        check_output("d opcode err_code", int'(err_code), 6);
        check_output("d opcode inflight", int'(inflight), 0);

        // Valid without ready is ignored
        apply_stimulus(1'b1, 1'b0, 7, 3, 0, 0, 1'b1, 1'b0, 0, 3, 3);
        check_output("unready err_valid", int'(err_valid), 0);
        check_output("unready inflight", int'(inflight), 0);

        // Bad A opcode and unknown D source together: lowest code wins
        apply_stimulus(1'b1, 1'b1, 7, 3, 0, 0, 1'b1, 1'b1, 0, 3, 3);
        check_output("priority err_code", int'(err_code), 1);

        // Misaligned Get still allocates
        send_a(4, 3, 1, 4);
        check_output("align err_code", int'(err_code), 3);
        check_output("align inflight", int'(inflight), 1);
        send_d(1, 3, 1);
        check_output("align retire err_valid", int'(err_valid), 0);

        // D size mismatch
        send_a(4, 2, 1, 0);
        send_d(1, 3, 1);
        check_output("d size err_code", int'(err_code), 7);
        check_output("d size inflight", int'(inflight), 0);

        // D source changes mid-burst
        send_a(4, 5, 0, 0);
        send_d(1, 5, 0);
        send_d(1, 5, 1);
        check_output("d source err_code", int'(err_code), 8);
        send_d(1, 5, 0);
        send_d(1, 5, 0);
        check_output("d source inflight", int'(inflight), 0);

        // Same-cycle retire and re-allocate on source 0
        send_a(4, 3, 0, 0);
        check_output("reuse pre inflight", int'(inflight), 1);
        apply_stimulus(1'b1, 1'b1, 4, 3, 0, 8, 1'b1, 1'b1, 1, 3, 0);
        check_output("reuse err_valid", int'(err_valid), 0);
        check_output("reuse inflight", int'(inflight), 1);
        send_d(1, 3, 0);
        check_output("reuse retire inflight", int'(inflight), 0);

        // Asynchronous reset during beat 2 of a 4-beat Put
        send_a(4, 3, 1, 0);
        send_a(0, 5, 2, 'h20);
        a_valid = 1'b1; a_ready = 1'b1; a_opcode = 3'd0; a_size = 3'd5;
        a_source = 2'd2; a_address = 25'h20;
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async rst err_valid", int'(err_valid), 0);
        check_output("async rst err_code", int'(err_code), 0);
        check_output("async rst err_sticky", int'(err_sticky), 0);
        check_output("async rst inflight", int'(inflight), 0);
        drive_idle();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send_a(0, 3, 0, 8);
        check_output("post rst err_valid", int'(err_valid), 0);
        check_output("post rst inflight", int'(inflight), 1);
        check_output("post rst sticky", int'(err_sticky), 0);
        send_d(0, 3, 0);
        check_output("post rst retire", int'(inflight), 0);
        check_output("post rst code", int'(err_code), 0);

        repeat (2) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
